// File: rtl/byte_move_if.sv
// Bundle of handshake, register-file and manipulation-unit signals around byte_move_ctrl.
// master = the sequencer, slave = instruction source, register file and manipulation unit.
interface byte_move_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic [2:0]  bm_op;
    logic [15:0] bm_dst_in;
    logic [7:0]  bm_byte_val;
    logic        bm_E;
    logic [15:0] bm_dst_out;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        done;
    logic        illegal;

    // Handshake: a word transfers on a rising clk edge where instr_valid && instr_ready;
    // the source must hold instr_valid and instr stable until that edge.
    modport master (
        input  instr_valid, instr, rf_rd_data, bm_dst_out,
        output instr_ready, rf_rd_addr, bm_op, bm_dst_in, bm_byte_val, bm_E,
               rf_wr_en, rf_wr_addr, rf_wr_data, done, illegal
    );

    modport slave (
        output instr_valid, instr, rf_rd_data, bm_dst_out,
        input  instr_ready, rf_rd_addr, bm_op, bm_dst_in, bm_byte_val, bm_E,
               rf_wr_en, rf_wr_addr, rf_wr_data, done, illegal
    );
endinterface

// File: rtl/byte_move_ctrl.sv
// Sequencer for MOVL/MOVLZ/MOVLS/MOVH/SWPB: decode, read destination, strobe the
// byte manipulation unit, wait WAIT_CYCLES, then write the result back.
module byte_move_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    byte_move_if.master  bus,
    output logic [2:0]   state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [12:0] SWPB_PAT = 13'b0100110110000;
    localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_range
        $error("byte_move_ctrl: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);
    end

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] instr_q;
    logic [2:0]  bm_op_q;
    logic [7:0]  bm_byte_val_q;
    logic [15:0] bm_dst_in_q;
    logic        bm_e_q, rf_wr_en_q, done_q, illegal_q;
    logic [2:0]  rf_wr_addr_q;
    logic [15:0] rf_wr_data_q;

    logic accept, in_legal, q_is_swpb;

    assign accept    = bus.instr_valid && bus.instr_ready;
    assign in_legal  = (bus.instr[15:13] == 3'b011) || (bus.instr[15:3] == SWPB_PAT);
    // Only legal words reach READ, so anything outside the MOVx group is SWPB.
    assign q_is_swpb = (instr_q[15:13] != 3'b011);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = in_legal ? S_READ : S_ERR;
            S_READ:   state_d = S_STROBE;
            S_STROBE: begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LD;
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) state_d = S_WRITE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WRITE:  state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            instr_q       <= 16'd0;
            bm_op_q       <= 3'd0;
            bm_byte_val_q <= 8'd0;
            bm_dst_in_q   <= 16'd0;
            bm_e_q        <= 1'b0;
            rf_wr_en_q    <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
            rf_wr_addr_q  <= 3'd0;
            rf_wr_data_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) instr_q <= bus.instr;
            if (state_q == S_READ) begin
                bm_dst_in_q <= bus.rf_rd_data;
                if (q_is_swpb) begin
                    bm_op_q       <= 3'd4;
                    bm_byte_val_q <= bus.rf_rd_data[7:0];
                end else begin
                    bm_op_q       <= {1'b0, instr_q[12:11]};
                    bm_byte_val_q <= instr_q[10:3];
                end
            end
            // Pulse outputs are registered from the state being entered.
            bm_e_q     <= (state_d == S_STROBE);
            rf_wr_en_q <= (state_d == S_WRITE);
            done_q     <= (state_d == S_WRITE);
            illegal_q  <= (state_d == S_ERR);
            if (state_d == S_WRITE) begin
                rf_wr_addr_q <= instr_q[2:0];
                rf_wr_data_q <= bus.bm_dst_out;
            end
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE) && !rst;
    assign bus.rf_rd_addr  = (state_q == S_READ) ? instr_q[2:0] : 3'd0;
    assign bus.bm_op       = bm_op_q;
    assign bus.bm_byte_val = bm_byte_val_q;
    assign bus.bm_dst_in   = bm_dst_in_q;
    assign bus.bm_E        = bm_e_q;
    assign bus.rf_wr_en    = rf_wr_en_q;
    assign bus.rf_wr_addr  = rf_wr_addr_q;
    assign bus.rf_wr_data  = rf_wr_data_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_byte_move_ctrl.sv
// Directed bench for byte_move_ctrl: one DUT with WAIT_CYCLES=1, one with WAIT_CYCLES=3,
// each with a register-file model and a model of the byte manipulation unit.
module tb_byte_move_ctrl;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    byte_move_if bus1 ();
    byte_move_if bus3 ();
    logic [2:0] state1, state3;

    byte_move_ctrl #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .state_o(state1));
    byte_move_ctrl #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3), .state_o(state3));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // register files and manipulation-unit models
    logic [15:0] rf1 [8];
    logic [15:0] rf3 [8];

    assign bus1.rf_rd_data = rf1[bus1.rf_rd_addr];
    assign bus3.rf_rd_data = rf3[bus3.rf_rd_addr];

    always @(posedge clk) begin
        if (bus1.rf_wr_en) rf1[bus1.rf_wr_addr] <= bus1.rf_wr_data;
        if (bus3.rf_wr_en) rf3[bus3.rf_wr_addr] <= bus3.rf_wr_data;
    end

    function automatic logic [15:0] bm_model(input logic [2:0] op, input logic [15:0] d,
                                             input logic [7:0] b);
        case (op)
            3'd0:    return {d[15:8], b};
            3'd1:    return {8'h00, b};
            3'd2:    return {{8{b[7]}}, b};
            3'd3:    return {b, d[7:0]};
            3'd4:    return {b, d[15:8]};
            default: return 16'hDEAD;
        endcase
    endfunction

    always @(posedge bus1.bm_E or posedge rst)
        if (rst) bus1.bm_dst_out <= 16'd0;
        else     bus1.bm_dst_out <= bm_model(bus1.bm_op, bus1.bm_dst_in, bus1.bm_byte_val);

    always @(posedge bus3.bm_E or posedge rst)
        if (rst) bus3.bm_dst_out <= 16'd0;
        else     bus3.bm_dst_out <= bm_model(bus3.bm_op, bus3.bm_dst_in, bus3.bm_byte_val);

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents w to dut1 and returns in the cycle after the accept edge (READ).
    task automatic issue1(input logic [15:0] w);
        int n = 0;
        while (bus1.instr_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus1.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue1_ready: instr_ready=%b required 1", bus1.instr_ready);
        end
        bus1.instr       = w;
        bus1.instr_valid = 1'b1;
        tick();
        bus1.instr_valid = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus1.instr_ready !== 1'b0 || bus3.instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: ready1=%b ready3=%b required 0", bus1.instr_ready, bus3.instr_ready);
        end
        checks++;
        if ({bus1.bm_E, bus1.rf_wr_en, bus1.done, bus1.illegal} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: E/wr/done/ill=%b required 0000",
                     {bus1.bm_E, bus1.rf_wr_en, bus1.done, bus1.illegal});
        end
        checks++;
        if ({bus1.bm_op, bus1.bm_byte_val, bus1.bm_dst_in, bus1.rf_wr_addr, bus1.rf_wr_data, bus1.rf_rd_addr} !== 49'd0) begin
            errors++;
            $display("FAIL reset_data: op=%h byte=%h din=%h waddr=%h wdata=%h raddr=%h required all 0",
                     bus1.bm_op, bus1.bm_byte_val, bus1.bm_dst_in, bus1.rf_wr_addr, bus1.rf_wr_data, bus1.rf_rd_addr);
        end
        checks++;
        if (state1 !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d required 0", state1);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus1.instr_ready !== 1'b1 || bus3.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: ready1=%b ready3=%b required 1", bus1.instr_ready, bus3.instr_ready);
        end
    endtask

    task automatic test_movl();
        rf1[3] = 16'h1234;
        issue1(16'h62D3);
        checks++;
        if (bus1.rf_rd_addr !== 3'd3 || bus1.bm_E !== 1'b0) begin
            errors++;
            $display("FAIL movl_read: rd_addr=%0d E=%b required 3,0", bus1.rf_rd_addr, bus1.bm_E);
        end
        tick();
        checks++;
        if (bus1.bm_E !== 1'b1 || bus1.bm_op !== 3'd0 || bus1.bm_byte_val !== 8'h5A || bus1.bm_dst_in !== 16'h1234) begin
            errors++;
            $display("FAIL movl_strobe: E=%b op=%0d byte=%h din=%h required 1,0,5a,1234",
                     bus1.bm_E, bus1.bm_op, bus1.bm_byte_val, bus1.bm_dst_in);
        end
        tick();
        checks++;
        if (bus1.bm_E !== 1'b0 || bus1.rf_wr_en !== 1'b0 || bus1.done !== 1'b0) begin
            errors++;
            $display("FAIL movl_wait: E=%b wr=%b done=%b required 0,0,0", bus1.bm_E, bus1.rf_wr_en, bus1.done);
        end
        tick();
        checks++;
        if (bus1.rf_wr_en !== 1'b1 || bus1.done !== 1'b1 || bus1.rf_wr_addr !== 3'd3 || bus1.rf_wr_data !== 16'h125A) begin
            errors++;
            $display("FAIL movl_write: wr=%b done=%b addr=%0d data=%h required 1,1,3,125a",
                     bus1.rf_wr_en, bus1.done, bus1.rf_wr_addr, bus1.rf_wr_data);
        end
        tick();
        checks++;
        if (bus1.done !== 1'b0 || bus1.rf_wr_en !== 1'b0 || bus1.instr_ready !== 1'b1 || rf1[3] !== 16'h125A) begin
            errors++;
            $display("FAIL movl_after: done=%b wr=%b ready=%b r3=%h required 0,0,1,125a",
                     bus1.done, bus1.rf_wr_en, bus1.instr_ready, rf1[3]);
        end
    endtask

    task automatic test_movh();
        rf1[0] = 16'h00CD;
        issue1(16'h7D58);
        tick();
        checks++;
        if (bus1.bm_E !== 1'b1 || bus1.bm_op !== 3'd3 || bus1.bm_byte_val !== 8'hAB || bus1.bm_dst_in !== 16'h00CD) begin
            errors++;
            $display("FAIL movh_strobe: E=%b op=%0d byte=%h din=%h required 1,3,ab,00cd",
                     bus1.bm_E, bus1.bm_op, bus1.bm_byte_val, bus1.bm_dst_in);
        end
        tick();
        tick();
        checks++;
        if (bus1.rf_wr_en !== 1'b1 || bus1.rf_wr_addr !== 3'd0 || bus1.rf_wr_data !== 16'hABCD) begin
            errors++;
            $display("FAIL movh_write: wr=%b addr=%0d data=%h required 1,0,abcd",
                     bus1.rf_wr_en, bus1.rf_wr_addr, bus1.rf_wr_data);
        end
        tick();
    endtask

    task automatic test_swpb();
        rf1[5] = 16'hBEEF;
        issue1(16'h4D85);
        tick();
        checks++;
        if (bus1.bm_E !== 1'b1 || bus1.bm_op !== 3'd4 || bus1.bm_byte_val !== 8'hEF || bus1.bm_dst_in !== 16'hBEEF) begin
            errors++;
            $display("FAIL swpb_strobe: E=%b op=%0d byte=%h din=%h required 1,4,ef,beef",
                     bus1.bm_E, bus1.bm_op, bus1.bm_byte_val, bus1.bm_dst_in);
        end
        tick();
        tick();
        checks++;
        if (bus1.rf_wr_en !== 1'b1 || bus1.done !== 1'b1 || bus1.rf_wr_addr !== 3'd5 || bus1.rf_wr_data !== 16'hEFBE) begin
            errors++;
            $display("FAIL swpb_write: wr=%b done=%b addr=%0d data=%h required 1,1,5,efbe",
                     bus1.rf_wr_en, bus1.done, bus1.rf_wr_addr, bus1.rf_wr_data);
        end
        tick();
        checks++;
        if (rf1[5] !== 16'hEFBE) begin
            errors++;
            $display("FAIL swpb_rf: r5=%h required efbe", rf1[5]);
        end
    endtask

    task automatic test_illegal();
        issue1(16'h0000);
        checks++;
        if (bus1.illegal !== 1'b1 || bus1.bm_E !== 1'b0 || bus1.rf_wr_en !== 1'b0 || bus1.done !== 1'b0
            || bus1.instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: ill=%b E=%b wr=%b done=%b ready=%b required 1,0,0,0,0",
                     bus1.illegal, bus1.bm_E, bus1.rf_wr_en, bus1.done, bus1.instr_ready);
        end
        tick();
        checks++;
        if (bus1.illegal !== 1'b0 || bus1.instr_ready !== 1'b1 || bus1.bm_E !== 1'b0 || bus1.rf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL illegal_after: ill=%b ready=%b E=%b wr=%b required 0,1,0,0",
                     bus1.illegal, bus1.instr_ready, bus1.bm_E, bus1.rf_wr_en);
        end
    endtask

    // dut3: two MOVLZ words with instr_valid held high; accept at c=0 and c=7
    task automatic test_back_to_back();
        rf3[1] = 16'hFFFF;
        rf3[2] = 16'h1111;
        checks++;
        if (bus3.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready0: ready=%b required 1", bus3.instr_ready);
        end
        bus3.instr       = 16'h6C01;
        bus3.instr_valid = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) bus3.instr = 16'h6BFA;
            if (c == 8) bus3.instr_valid = 1'b0;
            checks++;
            if (bus3.bm_E !== (c == 2 || c == 9)) begin
                errors++;
                $display("FAIL b2b_strobe c=%0d: E=%b required %b", c, bus3.bm_E, (c == 2 || c == 9));
            end
            checks++;
            if (bus3.done !== (c == 6 || c == 13) || bus3.rf_wr_en !== (c == 6 || c == 13)) begin
                errors++;
                $display("FAIL b2b_done c=%0d: done=%b wr=%b required %b", c, bus3.done, bus3.rf_wr_en,
                         (c == 6 || c == 13));
            end
            if (c == 6) begin
                checks++;
                if (bus3.rf_wr_addr !== 3'd1 || bus3.rf_wr_data !== 16'h0080) begin
                    errors++;
                    $display("FAIL b2b_write1: addr=%0d data=%h required 1,0080", bus3.rf_wr_addr, bus3.rf_wr_data);
                end
            end
            if (c == 7) begin
                checks++;
                if (bus3.instr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready7: ready=%b required 1", bus3.instr_ready);
                end
            end
            if (c == 13) begin
                checks++;
                if (bus3.rf_wr_addr !== 3'd2 || bus3.rf_wr_data !== 16'h007F) begin
                    errors++;
                    $display("FAIL b2b_write2: addr=%0d data=%h required 2,007f", bus3.rf_wr_addr, bus3.rf_wr_data);
                end
            end
        end
        checks++;
        if (rf3[1] !== 16'h0080 || rf3[2] !== 16'h007F) begin
            errors++;
            $display("FAIL b2b_rf: r1=%h r2=%h required 0080,007f", rf3[1], rf3[2]);
        end
    endtask

    task automatic test_reset_abort();
        logic seen = 1'b0;
        int   n    = 0;
        rf1[6] = 16'h4444;
        issue1(16'h608E);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus1.instr_ready !== 1'b1 || bus1.rf_wr_en !== 1'b0 || bus1.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_release: ready=%b wr=%b done=%b required 1,0,0",
                     bus1.instr_ready, bus1.rf_wr_en, bus1.done);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus1.rf_wr_en === 1'b1 || bus1.done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || rf1[6] !== 16'h4444) begin
            errors++;
            $display("FAIL abort_no_write: write_seen=%b r6=%h required 0,4444", seen, rf1[6]);
        end
        issue1(16'h742E);
        while (bus1.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus1.done !== 1'b1 || bus1.rf_wr_addr !== 3'd6 || bus1.rf_wr_data !== 16'hFF85) begin
            errors++;
            $display("FAIL abort_next: done=%b addr=%0d data=%h required 1,6,ff85",
                     bus1.done, bus1.rf_wr_addr, bus1.rf_wr_data);
        end
        tick();
        checks++;
        if (rf1[6] !== 16'hFF85) begin
            errors++;
            $display("FAIL abort_next_rf: r6=%h required ff85", rf1[6]);
        end
    endtask

    // sequence and final report
    initial begin
        rst              = 1'b1;
        bus1.instr_valid = 1'b0;
        bus1.instr       = 16'd0;
        bus3.instr_valid = 1'b0;
        bus3.instr       = 16'd0;
        for (int i = 0; i < 8; i++) begin
            rf1[i] = 16'd0;
            rf3[i] = 16'd0;
        end
        test_reset();
        test_movl();
        test_movh();
        test_swpb();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/byte_move_ctrl.md
# byte_move_ctrl

Sequencer for the byte-move instruction group (MOVL, MOVLZ, MOVLS, MOVH, SWPB).
- Sits directly upstream of the byte-value manipulation unit and between it and the register file.
- Accepts one instruction word over a valid/ready handshake and decodes it.
- Reads the destination register and presents operands plus a one-cycle enable strobe to the manipulation unit.
- Waits a programmable settle time, then writes the unit's result back to the register file.

## Interface
- WAIT_CYCLES, 1: cycles between the strobe cycle and the writeback cycle; legal range 1..15.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction word present
- instr  in  16  instruction word
- instr_ready  out  1  block can accept an instruction
- rf_rd_addr  out  3  register-file read address (file read is combinational)
- rf_rd_data  in  16  register-file read data, valid in the same cycle
- bm_op  out  3  manipulation op: 0 MOVL, 1 MOVLZ, 2 MOVLS, 3 MOVH, 4 SWPB
- bm_dst_in  out  16  current destination register value
- bm_byte_val  out  8  byte operand
- bm_E  out  1  manipulation-unit enable; the unit acts on its rising edge
- bm_dst_out  in  16  manipulation-unit result
- rf_wr_en / rf_wr_addr / rf_wr_data  out  1/3/16  register-file write port
- done  out  1  one-cycle pulse at writeback
- illegal  out  1  one-cycle pulse when the accepted word is not a byte-move instruction

## Operation
- Decode of the latched word:
  - instr[15:13]=3'b011 gives bm_op={1'b0,instr[12:11]}, bm_byte_val=instr[10:3], dst=instr[2:0].
  - instr[15:3]=13'b0100110110000 is SWPB: bm_op=4, dst=instr[2:0], and bm_byte_val=rf_rd_data[7:0] captured in READ.
  - Any other word is illegal.
- FSM states: IDLE, READ, STROBE, WAIT, WRITE, ERR.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr.
  - Next state is READ if the word is legal, otherwise ERR.
- READ:
  - rf_rd_addr=dst.
  - Register rf_rd_data into bm_dst_in; register bm_op and bm_byte_val.
  - Next state STROBE.
- STROBE: bm_E=1 for exactly this cycle; load the wait counter with WAIT_CYCLES; next state WAIT.
- WAIT: bm_E=0; decrement the counter; go to WRITE when it reaches 1.
- WRITE:
  - rf_wr_en=1, rf_wr_addr=dst, rf_wr_data=bm_dst_out sampled this cycle, done=1.
  - Next state IDLE.
- ERR: illegal=1; no register-file read or write and no bm_E; next state IDLE.
- bm_dst_in, bm_op and bm_byte_val hold stable from the end of READ until the return to IDLE.
- instr_ready=0 in every state except IDLE. The block does not buffer; upstream holds instr_valid/instr until it is accepted.
- rf_wr_en, done, illegal and bm_E are never high in the same cycle.

## Timing
- Reset values:
  - State is IDLE.
  - bm_E, rf_wr_en, done, illegal are 0.
  - bm_op, bm_byte_val, bm_dst_in, rf_wr_addr, rf_wr_data, rf_rd_addr are 0.
  - instr_ready is forced to 0 while rst is high.
- All outputs are registered except instr_ready and rf_rd_addr, which are decoded from state.
- With accept on edge t:
  - READ in cycle t+1, STROBE in t+2.
  - WAIT in t+3 .. t+2+WAIT_CYCLES.
  - WRITE/done in t+3+WAIT_CYCLES.
  - IDLE in t+4+WAIT_CYCLES, so the earliest next accept is at the end of that cycle.
- Illegal word accepted at t: illegal pulses in t+1, instr_ready is 1 again in t+2.
- Reset in any state returns to IDLE on the next edge.
  - No writeback is issued for an aborted instruction.
  - A reset coincident with WRITE still suppresses rf_wr_en, because reset has priority.
- WAIT_CYCLES values outside 1..15 are unsupported; an assertion must flag them at elaboration.

## Test plan
- MOVL #0x5A,R3 (0x62D3), R3=0x1234, bench model of the unit:
  - bm_op=0, bm_byte_val=0x5A, bm_dst_in=0x1234, bm_E high one cycle at t+2.
  - rf_wr_en at t+4 with addr 3 and data = model result 0x125A; done pulses once.
- MOVH #0xAB,R0 (0x7D58), R0=0x00CD: bm_op=3, bm_byte_val=0xAB; write to R0 of 0xABCD at t+4.
- SWPB R5 (0x4D85), R5=0xBEEF: bm_op=4, bm_byte_val=0xEF, bm_dst_in=0xBEEF; write 0xEFBE to R5.
- Illegal 0x0000 accepted:
  - illegal=1 in t+1 only; no bm_E, rf_wr_en or done.
  - instr_ready=1 at t+2.
- WAIT_CYCLES=3 with instr_valid held high across two MOVLZ words:
  - First done at t+6; second accept at t+7.
  - bm_E never high outside the STROBE cycles.
- rst pulsed for one cycle during WAIT: no rf_wr_en or done ever follows; instr_ready=1 in the cycle after rst falls; the next instruction completes normally.
